// File: rtl/oldland_mem_responder_if.sv
// Cache <-> memory word bus: one request channel from the cache way,
// one completion channel (ack/error pulse plus read data) back from memory.
interface oldland_mem_responder_if;
  logic        m_access;
  logic [29:0] m_addr;
  logic        m_wr_en;
  logic [31:0] m_wr_val;
  logic [3:0]  m_bytesel;
  logic [31:0] m_data;
  logic        m_ack;
  logic        m_error;
  logic        busy;

  // Cache side: issues requests, consumes completions.
  modport master (
    output m_access, m_addr, m_wr_en, m_wr_val, m_bytesel,
    input  m_data, m_ack, m_error, busy
  );

  // Memory side: consumes requests, produces completions.
  modport slave (
    input  m_access, m_addr, m_wr_en, m_wr_val, m_bytesel,
    output m_data, m_ack, m_error, busy
  );
endinterface

// File: rtl/oldland_mem_responder.sv
// Memory-side responder for the cache word bus. Serves reads and byte-lane
// writes from an internal word array after a fixed response latency, and
// accepts a new request in the response cycle so fills stream back-to-back.
// Addresses outside [BASE_WORD, BASE_WORD+MEM_WORDS) complete with m_error.
module oldland_mem_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [29:0] BASE_WORD = 30'h0,
  parameter int          LATENCY   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  oldland_mem_responder_if.slave       bus
);

  localparam int AW = $clog2(MEM_WORDS);

  // Reject illegal builds at elaboration time.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("oldland_mem_responder: LATENCY must be in 1..15");
  end
  if (MEM_WORDS < 16 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_size
    $error("oldland_mem_responder: MEM_WORDS must be a power of two >= 16");
  end
  if ((BASE_WORD & 30'(MEM_WORDS - 1)) != 30'h0) begin : g_bad_base
    $error("oldland_mem_responder: BASE_WORD must be aligned to MEM_WORDS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_data;
  logic        r_busy;

  // Latched request, held while the latency counts down.
  logic [29:0] r_addr;
  logic        r_wr;
  logic [31:0] r_wval;
  logic [3:0]  r_bsel;

  logic [31:0] r_mem [MEM_WORDS];

  logic          w_accept;
  logic          w_fire_now;
  logic          w_fire_wait;
  logic          w_fire;
  logic [29:0]   w_addr;
  logic          w_wr;
  logic [31:0]   w_wval;
  logic [3:0]    w_bsel;
  logic [29:0]   w_off;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_commit;

  // Requests are only looked at outside WAIT; with LATENCY=1 the accepting
  // edge is also the responding edge, so the live bus feeds the response
  // path directly instead of the latched copy.
  assign w_accept    = bus.m_access && (r_state != WAIT);
  assign w_fire_now  = w_accept && (LATENCY == 1);
  assign w_fire_wait = (r_state == WAIT) && (r_cnt == 4'd1);
  assign w_fire      = w_fire_now || w_fire_wait;

  assign w_addr = w_fire_now ? bus.m_addr    : r_addr;
  assign w_wr   = w_fire_now ? bus.m_wr_en   : r_wr;
  assign w_wval = w_fire_now ? bus.m_wr_val  : r_wval;
  assign w_bsel = w_fire_now ? bus.m_bytesel : r_bsel;

  // Unsigned wrap-around makes addresses below BASE_WORD land out of range too.
  assign w_off      = w_addr - BASE_WORD;
  assign w_in_range = (w_off < 30'(MEM_WORDS));
  assign w_idx      = w_off[AW-1:0];

  // Reset gates the write so a request caught by reset never reaches the array.
  assign w_commit = rst && w_fire && w_in_range && w_wr;

  // Capture the request on the accepting edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= bus.m_addr;
      r_wr   <= bus.m_wr_en;
      r_wval <= bus.m_wr_val;
      r_bsel <= bus.m_bytesel;
    end
  end

  // Commit enabled byte lanes on the edge that raises m_ack.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_bsel[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wval[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= 32'h0;
      r_busy  <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_data <= 32'h0;
      r_busy <= 1'b0;

      if (w_fire) begin
        r_ack <= w_in_range;
        r_err <= !w_in_range;
        if (w_in_range && !w_wr) begin
          r_data <= r_mem[w_idx];
        end
      end

      case (r_state)
        IDLE, RESP: begin
          if (bus.m_access) begin
            r_cnt  <= 4'(LATENCY - 1);
            r_busy <= 1'b1;
            r_state <= (LATENCY == 1) ? RESP : WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= RESP;
          end else begin
            r_cnt  <= r_cnt - 4'd1;
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign bus.m_data  = r_data;
  assign bus.m_ack   = r_ack;
  assign bus.m_error = r_err;
  assign bus.busy    = r_busy;

endmodule
